// File: rtl/seg_scan_driver_if.sv
// Bundle between the segment decoders and the display scanner.
// The host side drives the run/load controls and the patterns; the scanner side drives the display outputs.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [8*NUM_DIGITS-1:0] seg_in;
  logic [7:0]              seg_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;

  modport master (
    output enable, load, seg_in,
    input  seg_out, digit_sel, frame_done
  );

  modport slave (
    input  enable, load, seg_in,
    output seg_out, digit_sel, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner: it snapshots the digit patterns and drives a shared segment bus plus a one-hot digit select.
// Optional macro SEG_SCAN_BLANK_EN inserts BLANK_CYCLES dark cycles between lit digits to prevent ghosting.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_driver_if.slave  bus
);

  localparam int SEG_W   = 8 * NUM_DIGITS;
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

`ifdef SEG_SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_e;
`else
  typedef enum logic [0:0] {IDLE, SHOW} state_e;
`endif

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      pcnt_q;
  logic [SEG_W-1:0]      shadow_q;
  logic [SEG_W-1:0]      shadow_d;
  logic [7:0]            seg_out_q;
  logic [NUM_DIGITS-1:0] digit_sel_q;
  logic                  frame_done_q;
  logic [IDX_W-1:0]      idx_nxt;

  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) sel[i] = (idx == IDX_W'(i));
    return sel;
  endfunction

  // Constant-index selection keeps the slice in range for any NUM_DIGITS.
  function automatic logic [7:0] pattern(input logic [SEG_W-1:0] sh,
                                         input logic [IDX_W-1:0] idx);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == IDX_W'(i)) p = sh[8*i +: 8];
    return p;
  endfunction

  assign idx_nxt = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    shadow_d = shadow_q;
    if (bus.load) shadow_d = bus.seg_in;
  end

  always_ff @(posedge clk) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end

  // Outputs are computed from the pre-edge shadow, which gives loads a one-cycle display latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pcnt_q       <= '0;
      seg_out_q    <= '0;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else if (!bus.enable) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pcnt_q       <= '0;
      seg_out_q    <= '0;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q     <= SHOW;
          idx_q       <= '0;
          pcnt_q      <= '0;
          digit_sel_q <= onehot('0);
          seg_out_q   <= pattern(shadow_q, '0);
        end
        SHOW: begin
          if (pcnt_q == CNT_W'(PRESCALE - 1)) begin
            pcnt_q <= '0;
`ifdef SEG_SCAN_BLANK_EN
            state_q     <= BLANK;
            digit_sel_q <= '0;
            seg_out_q   <= '0;
`else
            idx_q        <= idx_nxt;
            digit_sel_q  <= onehot(idx_nxt);
            seg_out_q    <= pattern(shadow_q, idx_nxt);
            frame_done_q <= (idx_nxt == '0);
`endif
          end else begin
            pcnt_q      <= pcnt_q + 1'b1;
            digit_sel_q <= onehot(idx_q);
            seg_out_q   <= pattern(shadow_q, idx_q);
          end
        end
`ifdef SEG_SCAN_BLANK_EN
        BLANK: begin
          if (pcnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_q      <= SHOW;
            pcnt_q       <= '0;
            idx_q        <= idx_nxt;
            digit_sel_q  <= onehot(idx_nxt);
            seg_out_q    <= pattern(shadow_q, idx_nxt);
            frame_done_q <= (idx_nxt == '0);
          end else begin
            pcnt_q      <= pcnt_q + 1'b1;
            digit_sel_q <= '0;
            seg_out_q   <= '0;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          pcnt_q      <= '0;
          digit_sel_q <= '0;
          seg_out_q   <= '0;
        end
      endcase
    end
  end

  assign bus.seg_out    = seg_out_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: 4 digits, 3-cycle slots, and 2 blank cycles when SEG_SCAN_BLANK_EN is defined.
module tb_seg_scan_driver;
  localparam int ND = 4;
  localparam int P  = 3;
  localparam int BC = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int BL = BC;
`else
  localparam int BL = 0;
`endif
  localparam int L     = P + BL;
  localparam int FRAME = ND * L;
  localparam logic [31:0] PAT = 32'h796D_664F;

  typedef struct {
    logic [ND-1:0] sel;
    logic [7:0]    seg;
    logic          fd;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus();

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .PRESCALE    (P),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Expected output n edges after the scan starts from IDLE.
  function automatic exp_t slot(int n, logic [31:0] pat, string tag);
    exp_t e;
    int   c;
    int   d;
    c = n % L;
    d = (n / L) % ND;
    e.sel = '0;
    e.seg = '0;
    if (c < P) begin
      e.sel[d] = 1'b1;
      e.seg    = pat[8*d +: 8];
    end
    e.fd  = (n > 0) && (n % FRAME == 0);
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t dark(string tag);
    exp_t e;
    e.sel = '0;
    e.seg = '0;
    e.fd  = 1'b0;
    e.tag = tag;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      rst        = (k < 2);
      bus.enable = 1'b0;
      bus.load   = 1'b0;
      sb.push_back(dark("reset_idle"));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.digit_sel !== e.sel || bus.seg_out !== e.seg || bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s: got sel=%b seg=%h fd=%b want sel=%b seg=%h fd=%b",
                 e.tag, bus.digit_sel, bus.seg_out, bus.frame_done, e.sel, e.seg, e.fd);
      end
    end
  endtask

  task automatic test_scan_order();
    exp_t e;
    for (int k = 0; k <= 2*FRAME + 2; k++) begin
      if (k == 0) begin
        bus.load = 1'b1; bus.seg_in = PAT; bus.enable = 1'b0;
        sb.push_back(dark("scan_preload"));
      end else if (k <= 2*FRAME + 1) begin
        bus.load = 1'b0; bus.enable = 1'b1;
        sb.push_back(slot(k - 1, PAT, "scan_order"));
      end else begin
        bus.enable = 1'b0;
        sb.push_back(dark("scan_stop"));
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.digit_sel !== e.sel || bus.seg_out !== e.seg || bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s: got sel=%b seg=%h fd=%b want sel=%b seg=%h fd=%b",
                 e.tag, bus.digit_sel, bus.seg_out, bus.frame_done, e.sel, e.seg, e.fd);
      end
    end
  endtask

  // Load low byte 0x3F mid-digit 0, then byte 1 = 0x06 on the advance edge into digit 1.
  task automatic test_mid_load();
    exp_t        e;
    logic [31:0] ep;
    for (int k = 0; k <= L + 3; k++) begin
      if (k <= L + 2) begin
        bus.enable = 1'b1;
        bus.load   = (k == 1) || (k == L);
        if (k == 1) bus.seg_in = {PAT[31:8], 8'h3F};
        if (k == L) bus.seg_in = {PAT[31:16], 8'h06, 8'h3F};
        ep = PAT;
        if (k >= 2)     ep[7:0]  = 8'h3F;
        if (k >= L + 1) ep[15:8] = 8'h06;
        sb.push_back(slot(k, ep, "mid_load"));
      end else begin
        bus.enable = 1'b0;
        bus.load   = 1'b1;
        bus.seg_in = PAT;
        sb.push_back(dark("mid_load_stop"));
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.digit_sel !== e.sel || bus.seg_out !== e.seg || bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s: got sel=%b seg=%h fd=%b want sel=%b seg=%h fd=%b",
                 e.tag, bus.digit_sel, bus.seg_out, bus.frame_done, e.sel, e.seg, e.fd);
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_disable();
    exp_t e;
    for (int k = 0; k <= 3*L + 5; k++) begin
      if (k <= 2*L + 1) begin
        bus.enable = 1'b1;
        sb.push_back(slot(k, PAT, "pre_disable"));
      end else if (k <= 2*L + 3) begin
        bus.enable = 1'b0;
        sb.push_back(dark("disabled"));
      end else if (k <= 3*L + 4) begin
        bus.enable = 1'b1;
        sb.push_back(slot(k - (2*L + 4), PAT, "reenable"));
      end else begin
        bus.enable = 1'b0;
        sb.push_back(dark("disable_stop"));
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.digit_sel !== e.sel || bus.seg_out !== e.seg || bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s: got sel=%b seg=%h fd=%b want sel=%b seg=%h fd=%b",
                 e.tag, bus.digit_sel, bus.seg_out, bus.frame_done, e.sel, e.seg, e.fd);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int k = 0; k <= 3*L + 5; k++) begin
      if (k <= 3*L + 1) begin
        rst = 1'b0; bus.enable = 1'b1;
        sb.push_back(slot(k, PAT, "pre_reset"));
      end else if (k == 3*L + 2) begin
        rst = 1'b1; bus.enable = 1'b1;
        sb.push_back(dark("reset_mid"));
      end else if (k <= 3*L + 4) begin
        rst = 1'b0; bus.enable = 1'b1;
        sb.push_back(slot(k - (3*L + 3), 32'h0, "after_reset"));
      end else begin
        bus.enable = 1'b0;
        sb.push_back(dark("reset_mid_stop"));
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.digit_sel !== e.sel || bus.seg_out !== e.seg || bus.frame_done !== e.fd) begin
        errors++;
        $display("FAIL %s: got sel=%b seg=%h fd=%b want sel=%b seg=%h fd=%b",
                 e.tag, bus.digit_sel, bus.seg_out, bus.frame_done, e.sel, e.seg, e.fd);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    bus.seg_in = '0;
    test_reset();
    test_scan_order();
    test_mid_load();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment display scanner sitting directly downstream of the per-digit segment decoders in the 8-bit multiplier display path. Takes NUM_DIGITS 8-bit segment patterns (bit 7 = dp, bits 6:0 = g..a, active-high), snapshots them on a load strobe and drives one shared segment bus plus a one-hot digit select, rotating digits at a programmable refresh rate.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- PRESCALE, 50000: clk cycles each digit is lit; legal range ≥1.
- BLANK_CYCLES, 16: dead-time cycles between digits, used only with SEG_SCAN_BLANK_EN; legal range ≥1.

- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  scan run; low forces display dark.
- load  input  1  snapshot strobe; captures seg_in into the shadow register.
- seg_in  input  8*NUM_DIGITS  digit i pattern at bits [8i+7:8i], digit 0 rightmost.
- seg_out  output  8  registered segment bus, active-high.
- digit_sel  output  NUM_DIGITS  registered one-hot digit enable, active-high; all-zero when dark.
- frame_done  output  1  registered one-cycle pulse at each frame wrap.

## Operation
- Reset values: seg_out=0, digit_sel=0, frame_done=0, shadow=0, idx=0, pcnt=0, state IDLE.
- Shadow register: loaded from seg_in at every edge with load=1, independent of enable/state; otherwise holds.
- States: IDLE, SHOW, BLANK (BLANK exists only with SEG_SCAN_BLANK_EN).
- IDLE: seg_out=0, digit_sel=0, idx=0, pcnt=0. enable=1 → SHOW with idx=0.
- SHOW: digit_sel=one-hot(idx), seg_out=shadow[8*idx+7:8*idx], refreshed every cycle. pcnt counts 0..PRESCALE-1; at PRESCALE-1 pcnt→0 and digit advances (directly, or via BLANK).
- Advance: idx→idx+1, wrapping NUM_DIGITS-1→0. Wrap pulses frame_done on the first cycle of digit 0 of the new frame; the initial entry from IDLE does not pulse.
- BLANK: seg_out=0, digit_sel=0 for BLANK_CYCLES cycles (pcnt reused), then SHOW with the next idx.
- enable=0 in any state → IDLE at the next edge; outputs dark the same edge; idx and pcnt cleared, so re-enable always restarts at digit 0.
- NUM_DIGITS=1: digit_sel stays 1 in SHOW; frame_done pulses every PRESCALE cycles (every PRESCALE+BLANK_CYCLES with blanking).
- rst dominates enable and load; reset mid-scan returns every register to reset values at that edge.

## Timing
- enable sampled high at edge E0 (from IDLE): at E0 digit_sel=…0001, seg_out=shadow digit 0.
- Without blanking: digit k lit for exactly PRESCALE cycles; frame period NUM_DIGITS×PRESCALE cycles.
- With blanking: each slot PRESCALE lit + BLANK_CYCLES dark; frame period NUM_DIGITS×(PRESCALE+BLANK_CYCLES).
- load at edge L: shadow updated at L; seg_out shows new value from edge L+1 if that digit is lit (1-cycle latency); no effect on counters.
- load coincident with a digit advance: new digit shows old shadow for its first cycle, new value from the following cycle.
- digit_sel and seg_out change on the same edge; never two bits of digit_sel high.

## Configuration
- SEG_SCAN_BLANK_EN defined: BLANK state compiled in; BLANK_CYCLES dark cycles between every lit digit, including the wrap last→0 (anti-ghosting).
- Undefined: no BLANK state; digits switch back-to-back; BLANK_CYCLES ignored.

## Test plan
- Reset/idle: NUM_DIGITS=4, PRESCALE=3; rst high 2 cycles, enable=0 → seg_out=0x00, digit_sel=0000, frame_done=0 throughout.
- Scan order: load seg_in=0x79_6D_66_4F, enable=1 → digit_sel 0001/0010/0100/1000 each 3 cycles with seg_out 0x4F/0x66/0x6D/0x79; frame_done single pulse at cycle 12 with digit_sel=0001.
- Mid-digit load: while digit 0 lit, load seg_in low byte 0x3F → seg_out 0x3F exactly one cycle after load edge, digit timing unchanged.
- Disable/re-enable: drop enable during digit 2 → next edge dark; re-enable → restarts at digit 0 with full 3-cycle slot, no frame_done.
- Blanking (SEG_SCAN_BLANK_EN, BLANK_CYCLES=2): each 3-cycle lit slot followed by 2 cycles of digit_sel=0000, seg_out=0x00; frame period 20 cycles.
- Reset mid-scan: assert rst during digit 3 → all outputs zero at that edge, shadow=0; after release with enable=1, digit 0 shows 0x00.
